// File: rtl/hwpe_ctrl_uloop_issue_pkg.sv
// Shared types for the uloop issue stage: uloop engine handshake structs,
// the descriptor handed to the streamer controllers, and the FSM state enum.
package hwpe_ctrl_uloop_issue_pkg;

  localparam int unsigned ULOOP_MAX_NB_LOOPS      = 6;
  localparam int unsigned ULOOP_MAX_NB_REG        = 4;
  localparam int unsigned ULOOP_REG_WIDTH         = 32;
  localparam int unsigned ULOOP_ISSUE_MAX_STREAMS = 4;

  typedef struct packed {
    logic enable;
    logic clear;
  } ctrl_uloop_t;

  typedef struct packed {
    logic                                             valid;
    logic                                             done;
    logic [ULOOP_MAX_NB_REG-1:0][ULOOP_REG_WIDTH-1:0] offs;
    logic [ULOOP_MAX_NB_LOOPS-1:0]                    idx_update;
  } flags_uloop_t;

  typedef struct packed {
    logic [ULOOP_ISSUE_MAX_STREAMS-1:0][ULOOP_REG_WIDTH-1:0] addr;
    logic [ULOOP_MAX_NB_LOOPS-1:0]                           idx_update;
    logic                                                    last;
  } uloop_issue_desc_t;

  typedef enum logic [2:0] {
    UI_IDLE,
    UI_CLR,
    UI_REQ,
    UI_WAIT,
    UI_DRAIN
  } uloop_issue_state_t;

  // Address arithmetic wraps at the register width; the carry is dropped.
  function automatic logic [ULOOP_REG_WIDTH-1:0] uloop_issue_wrap_add(
    input logic [ULOOP_REG_WIDTH-1:0] a,
    input logic [ULOOP_REG_WIDTH-1:0] b
  );
    return a + b;
  endfunction

endpackage

// File: rtl/hwpe_ctrl_desc_fifo.sv
// Small descriptor FIFO with synchronous reset/clear. Pointers wrap modulo
// DEPTH so any depth >= 1 works. data_o reads as zero while empty.
module hwpe_ctrl_desc_fifo #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  pop_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_cnt;
  logic                  w_do_push;
  logic                  w_do_pop;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty_o   = (r_cnt == '0);
  assign full_o    = (r_cnt == CNT_W'(DEPTH));
  assign w_do_pop  = pop_i & ~empty_o;
  // A push into a full FIFO is only accepted when a pop frees a slot this cycle.
  assign w_do_push = push_i & (~full_o | w_do_pop);
  assign data_o    = empty_o ? '0 : r_mem[r_rptr];

  // Pointer and occupancy bookkeeping; reset and clear both flush.
  always_ff @(posedge clk_i) begin
    if (rst_i | clear_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_do_push) r_wptr <= next_ptr(r_wptr);
      if (w_do_pop)  r_rptr <= next_ptr(r_rptr);
      case ({w_do_push, w_do_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage write; contents need no reset because data_o is masked when empty.
  always_ff @(posedge clk_i) begin
    if (w_do_push) r_mem[r_wptr] <= data_i;
  end

endmodule

// File: rtl/hwpe_ctrl_uloop_issue.sv
// Steps the uloop engine one iteration at a time, turns each iteration's
// offsets into per-stream base addresses and queues the descriptors for the
// streamer controllers.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// UI_IDLE  | waiting for start_i
// UI_CLR   | one-cycle clear of the uloop engine
// UI_REQ   | request next iteration once the FIFO has room
// UI_WAIT  | one request outstanding, waiting for flags.valid
// UI_DRAIN | last descriptor pushed, waiting for the FIFO to empty
module hwpe_ctrl_uloop_issue
  import hwpe_ctrl_uloop_issue_pkg::*;
#(
  parameter int unsigned NB_STREAMS = ULOOP_ISSUE_MAX_STREAMS,
  parameter int unsigned NB_REG     = ULOOP_MAX_NB_REG,
  parameter int unsigned NB_LOOPS   = ULOOP_MAX_NB_LOOPS,
  parameter int unsigned ADDR_WIDTH = ULOOP_REG_WIDTH,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned SEL_W      = (NB_REG > 1) ? $clog2(NB_REG) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  clear_i,
  input  logic                                  start_i,
  input  logic [NB_STREAMS-1:0][ADDR_WIDTH-1:0] base_addr_i,
  input  logic [NB_STREAMS-1:0][SEL_W-1:0]      offs_sel_i,
  output ctrl_uloop_t                           uloop_ctrl_o,
  input  flags_uloop_t                          uloop_flags_i,
  output logic                                  desc_valid_o,
  input  logic                                  desc_ready_i,
  output uloop_issue_desc_t                     desc_o,
  output logic                                  busy_o,
  output logic                                  done_o
);

  uloop_issue_state_t r_state;
  uloop_issue_state_t w_state_next;
  logic               w_flush;
  logic               w_en;
  logic               w_clr_state;
  logic               w_push;
  logic               w_done;
  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  uloop_issue_desc_t  w_desc_in;
  uloop_issue_desc_t  w_desc_out;

  assign w_flush = rst_i | clear_i;

  // State register; reset and soft clear abandon any outstanding request.
  always_ff @(posedge clk_i) begin
    if (w_flush) r_state <= UI_IDLE;
    else         r_state <= w_state_next;
  end

  // Next-state and per-state strobes.
  always_comb begin
    w_state_next = r_state;
    w_en         = 1'b0;
    w_clr_state  = 1'b0;
    w_push       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      UI_IDLE: begin
        if (start_i) w_state_next = UI_CLR;
      end
      UI_CLR: begin
        w_clr_state  = 1'b1;
        w_state_next = UI_REQ;
      end
      UI_REQ: begin
        // Only ask for an iteration when its descriptor is guaranteed a slot.
        if (!w_full) begin
          w_en         = 1'b1;
          w_state_next = UI_WAIT;
        end
      end
      UI_WAIT: begin
        if (uloop_flags_i.valid) begin
          w_push       = 1'b1;
          w_state_next = uloop_flags_i.done ? UI_DRAIN : UI_REQ;
        end
      end
      UI_DRAIN: begin
        if (w_empty) begin
          w_done       = 1'b1;
          w_state_next = UI_IDLE;
        end
      end
      default: w_state_next = UI_IDLE;
    endcase
  end

  // Per-stream address adders plus index-update and last flags.
  always_comb begin
    w_desc_in = '0;
    for (int s = 0; s < NB_STREAMS; s++) begin
      w_desc_in.addr[s] = uloop_issue_wrap_add(base_addr_i[s],
                                               uloop_flags_i.offs[offs_sel_i[s]]);
    end
    for (int l = 0; l < NB_LOOPS; l++) begin
      w_desc_in.idx_update[l] = uloop_flags_i.idx_update[l];
    end
    w_desc_in.last = uloop_flags_i.done;
  end

  // Engine control; enable is suppressed whenever a clear is being issued.
  always_comb begin
    uloop_ctrl_o        = '0;
    uloop_ctrl_o.clear  = clear_i | w_clr_state;
    uloop_ctrl_o.enable = w_en & ~w_flush;
  end

  assign w_pop        = desc_valid_o & desc_ready_i;
  assign desc_valid_o = ~w_empty;
  assign desc_o       = w_desc_out;
  assign busy_o       = (r_state != UI_IDLE);
  assign done_o       = w_done & ~w_flush;

  hwpe_ctrl_desc_fifo #(
    .DATA_WIDTH ($bits(uloop_issue_desc_t)),
    .DEPTH      (FIFO_DEPTH)
  ) i_desc_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (clear_i),
    .push_i  (w_push),
    .data_i  (w_desc_in),
    .pop_i   (w_pop),
    .data_o  (w_desc_out),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

endmodule

// File: tb/tb_hwpe_ctrl_uloop_issue.sv
// Bench for hwpe_ctrl_uloop_issue: a uloop engine stub replies to enables
// with planned iterations and records the expected descriptor; a monitor
// checks popped descriptors, done_o timing and output stability.
module tb_hwpe_ctrl_uloop_issue;
  import hwpe_ctrl_uloop_issue_pkg::*;

  localparam int NS = 4;
  localparam int NR = 4;
  localparam int NL = 6;
  localparam int AW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  rst = 1'b1, clr = 1'b0, start = 1'b0, ready = 1'b0;
  logic [NS-1:0][AW-1:0] base;
  logic [NS-1:0][1:0]    sel;
  ctrl_uloop_t           ctrl;
  flags_uloop_t          flags;
  logic                  dvalid, busy, done;
  uloop_issue_desc_t     desc;

  hwpe_ctrl_uloop_issue #(
    .NB_STREAMS(NS), .NB_REG(NR), .NB_LOOPS(NL), .ADDR_WIDTH(AW), .FIFO_DEPTH(2)
  ) dut (
    .clk_i(clk), .rst_i(rst), .clear_i(clr), .start_i(start),
    .base_addr_i(base), .offs_sel_i(sel), .uloop_ctrl_o(ctrl),
    .uloop_flags_i(flags), .desc_valid_o(dvalid), .desc_ready_i(ready),
    .desc_o(desc), .busy_o(busy), .done_o(done)
  );

  typedef struct {
    logic [NS-1:0][AW-1:0] base;
    logic [NS-1:0][1:0]    sel;
    logic [NR-1:0][AW-1:0] offs;
    logic [NL-1:0]         idx;
    logic                  last;
    int                    lat;
  } iter_t;

  iter_t             plan[$];
  uloop_issue_desc_t exp_q[$];
  int errors = 0, checks = 0;
  int n_enable = 0, n_clear = 0;
  int cyc_cnt = 0, t_start = 0;
  bit spurious = 1'b0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input string name, input logic [159:0] act, input logic [159:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Reference: each stream's address is its base plus the selected offset, mod 2^32.
  function automatic uloop_issue_desc_t model(input iter_t it);
    uloop_issue_desc_t d;
    longint unsigned   sum;
    d = '0;
    for (int s = 0; s < NS; s++) begin
      sum       = (64'(it.base[s]) + 64'(it.offs[it.sel[s]])) % 64'h1_0000_0000;
      d.addr[s] = AW'(sum);
    end
    d.idx_update = it.idx;
    d.last       = it.last;
    return d;
  endfunction

  function automatic iter_t rand_iter(input bit last, input int lat);
    iter_t it;
    for (int s = 0; s < NS; s++) begin
      it.base[s] = $urandom;
      it.sel[s]  = 2'($urandom_range(0, 3));
    end
    for (int r = 0; r < NR; r++) it.offs[r] = $urandom;
    it.idx  = 6'($urandom);
    it.last = last;
    it.lat  = lat;
    return it;
  endfunction

  // uloop engine stub: answers each enable after the planned latency.
  initial begin
    bit    pend = 1'b0;
    int    cnt  = 0;
    iter_t it;
    flags = '0;
    base  = '0;
    sel   = '0;
    forever begin
      @(posedge clk); #1;
      flags.valid = 1'b0;
      if (spurious) begin
        flags.valid = 1'b1;
        flags.done  = 1'b1;
        for (int r = 0; r < NR; r++) flags.offs[r] = $urandom;
        spurious = 1'b0;
      end else if (pend) begin
        if (cnt <= 1) begin
          pend = 1'b0;
          if (plan.size() > 0) begin
            it               = plan.pop_front();
            base             = it.base;
            sel              = it.sel;
            flags.offs       = it.offs;
            flags.idx_update = it.idx;
            flags.done       = it.last;
            flags.valid      = 1'b1;
            exp_q.push_back(model(it));
          end
        end else cnt--;
      end
      @(negedge clk);
      if (ctrl.clear) begin pend = 1'b0; n_clear++; end
      if (ctrl.enable) begin
        n_enable++;
        pend = 1'b1;
        cnt  = (plan.size() > 0) ? plan[0].lat : 1;
      end
    end
  end

  // Monitor: scoreboard pops, done_o one cycle after the last pop, stability.
  initial begin
    bit                done_due = 1'b0, done_next, prev_done = 1'b0, hold_v = 1'b0;
    uloop_issue_desc_t held = '0, e;
    forever begin
      @(negedge clk);
      if (rst) begin
        done_due = 1'b0; prev_done = 1'b0; hold_v = 1'b0;
        continue;
      end
      check("done_o", done, done_due);
      if (prev_done) check("busy_after_done", busy, 1'b0);
      check("enable_with_clear", ctrl.enable & ctrl.clear, 1'b0);
      if (hold_v && dvalid) check("desc_stable", desc, held);
      done_next = 1'b0;
      if (dvalid && ready) begin
        if (exp_q.size() == 0) check("desc_unexpected", desc, '0);
        else begin
          e = exp_q.pop_front();
          check("desc", desc, e);
          done_next = e.last;
        end
      end
      done_due  = done_next;
      prev_done = done;
      hold_v    = dvalid && !ready;
      held      = desc;
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic raw_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic pulse_start();
    t_start = cyc_cnt;
    raw_start();
  endtask

  task automatic wait_valid(input string name, input int budget);
    bit got = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (dvalid) begin got = 1'b1; break; end
    end
    check(name, got, 1'b1);
  endtask

  // Wait for done_o, optionally toggling ready; returns start-to-done cycles.
  task automatic wait_done(input string name, input int budget, input bit rand_ready,
                           output int lat);
    bit got = 1'b0;
    lat = -1;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      if (done) begin got = 1'b1; lat = cyc_cnt - t_start; break; end
      step();
      if (rand_ready) ready = ($urandom_range(0, 2) != 0);
    end
    check(name, got, 1'b1);
    step();
    ready = 1'b1;
  endtask

  // Run a job of n random iterations; with ready held high the start-to-done
  // time is 2 + sum(latencies) + (n-1) + 2 cycles.
  task automatic run_job(input int n, input int max_lat, input bit rand_ready);
    int lsum = 0, lat, l;
    for (int i = 0; i < n; i++) begin
      l = $urandom_range(1, max_lat);
      lsum += l;
      plan.push_back(rand_iter(i == n - 1, l));
    end
    ready = rand_ready ? 1'b0 : 1'b1;
    pulse_start();
    wait_done("job_done", 500, rand_ready, lat);
    if (!rand_ready) check("job_latency", lat, 2 + lsum + (n - 1) + 2);
    check("job_queue_empty", exp_q.size(), 0);
  endtask

  task automatic run_hold(input string name, input iter_t it, input logic [NS-1:0][AW-1:0] exp_addr);
    int lat;
    plan.push_back(it);
    ready = 1'b0;
    pulse_start();
    wait_valid({name, "_valid"}, 20);
    check({name, "_addr"}, desc.addr, exp_addr);
    step();
    ready = 1'b1;
    wait_done({name, "_done"}, 20, 1'b0, lat);
  endtask

  initial begin
    iter_t it;
    int    e0, c0, lat;
    logic [NS-1:0][AW-1:0] ea;

    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_desc_valid", dvalid, 1'b0);
    check("rst_desc", desc, '0);
    check("rst_ctrl", ctrl, '0);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    step();

    // Single iteration, cycle by cycle from the start pulse.
    it = rand_iter(1'b1, 1);
    it.base[0] = 32'h1000; it.sel[0] = 2'd0; it.offs[0] = 32'h40;
    plan.push_back(it);
    ready = 1'b1;
    start = 1'b1;
    t_start = cyc_cnt;
    @(negedge clk); check("t0_clear", ctrl.clear, 1'b0);
    step(); start = 1'b0;
    @(negedge clk); check("t1_clear", ctrl.clear, 1'b1);
    check("t1_enable", ctrl.enable, 1'b0);
    @(negedge clk); check("t2_enable", ctrl.enable, 1'b1);
    @(negedge clk); check("t3_valid", dvalid, 1'b0);
    check("t3_busy", busy, 1'b1);
    @(negedge clk); check("t4_valid", dvalid, 1'b1);
    check("t4_addr0", desc.addr[0], 32'h1040);
    check("t4_last", desc.last, 1'b1);
    @(negedge clk); check("t5_done", done, 1'b1);
    @(negedge clk); check("t6_busy", busy, 1'b0);
    check("t6_done", done, 1'b0);
    step();

    // Wrap-around address arithmetic.
    it = rand_iter(1'b1, 1);
    for (int s = 0; s < NS; s++) begin
      it.base[s] = 32'hFFFF_FFF0; it.sel[s] = 2'd0; ea[s] = 32'h10;
    end
    it.offs[0] = 32'h20;
    run_hold("wrap", it, ea);

    // Per-stream offset select.
    it = rand_iter(1'b1, 1);
    for (int s = 0; s < NS; s++) begin
      it.base[s] = '0;
      it.sel[s]  = 2'(3 - s);
      it.offs[s] = 32'(16 * (s + 1));
      ea[s]      = 32'(16 * (4 - s));
    end
    run_hold("sel", it, ea);

    // Backpressure: two pushes fill the FIFO and the FSM parks in REQ.
    for (int i = 0; i < 4; i++) plan.push_back(rand_iter(i == 3, 1));
    ready = 1'b0;
    e0 = n_enable;
    pulse_start();
    repeat (14) step();
    @(negedge clk);
    check("bp_enables", n_enable - e0, 2);
    check("bp_enable_now", ctrl.enable, 1'b0);
    check("bp_busy", busy, 1'b1);
    check("bp_valid", dvalid, 1'b1);
    step();
    ready = 1'b1;
    wait_done("bp_done", 60, 1'b0, lat);
    check("bp_queue_empty", exp_q.size(), 0);

    // Soft clear while waiting with one descriptor buffered.
    plan.push_back(rand_iter(1'b0, 1));
    plan.push_back(rand_iter(1'b0, 6));
    plan.push_back(rand_iter(1'b1, 1));
    ready = 1'b0;
    pulse_start();
    repeat (4) step();
    clr = 1'b1;
    @(negedge clk);
    check("clr_ctrl_clear", ctrl.clear, 1'b1);
    check("clr_ctrl_enable", ctrl.enable, 1'b0);
    check("clr_valid_before", dvalid, 1'b1);
    step();
    clr = 1'b0;
    plan.delete();
    exp_q.delete();
    @(negedge clk);
    check("clr_busy", busy, 1'b0);
    check("clr_valid", dvalid, 1'b0);
    repeat (8) step();
    check("clr_no_stray_desc", exp_q.size(), 0);
    run_job(2, 2, 1'b0);

    // start coincident with clear stays idle.
    start = 1'b1; clr = 1'b1;
    step();
    start = 1'b0; clr = 1'b0;
    @(negedge clk);
    check("startclr_busy", busy, 1'b0);
    check("startclr_noclr", ctrl.clear, 1'b0);
    step();

    // flags.valid while idle is ignored.
    spurious = 1'b1;
    repeat (3) step();
    @(negedge clk);
    check("spurious_valid", dvalid, 1'b0);
    check("spurious_busy", busy, 1'b0);
    step();

    // Late replies and start pulses while busy.
    plan.push_back(rand_iter(1'b0, 5));
    plan.push_back(rand_iter(1'b1, 5));
    ready = 1'b1;
    e0 = n_enable; c0 = n_clear;
    pulse_start();
    repeat (3) step();
    raw_start();
    repeat (4) step();
    raw_start();
    wait_done("late_done", 60, 1'b0, lat);
    check("late_latency", lat, 15);
    check("late_enables", n_enable - e0, 2);
    check("late_clears", n_clear - c0, 1);
    check("late_queue_empty", exp_q.size(), 0);

    // Randomised jobs.
    for (int j = 0; j < 12; j++) run_job($urandom_range(1, 5), 3, j[0]);

    repeat (4) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hwpe_ctrl_uloop_issue.md
# hwpe_ctrl_uloop_issue

Downstream consumer of the HWPE microcode loop engine (run with shadowed flags). It sequences that engine one iteration at a time and latches each iteration's offsets and index-update flags. It then forms one base address per streamer and hands the resulting descriptors to the streamer controllers through a small FIFO with a valid/ready handshake. It sits between the uloop engine and the streamer ctrl ports inside the HWPE controller.

## Interface
- NB_STREAMS, 4: streamer address channels per descriptor
- NB_REG, 4: uloop offset registers selectable
- NB_LOOPS, 6: loop levels reported in idx_update
- ADDR_WIDTH, 32: address width (also uloop REG_WIDTH)
- FIFO_DEPTH, 2: descriptor buffer depth, ≥1
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- clear_i  in  1  synchronous soft clear, same effect as rst_i
- start_i  in  1  one-cycle start pulse; ignored unless IDLE
- base_addr_i  in  NB_STREAMS×ADDR_WIDTH  per-stream base, sampled every push
- offs_sel_i  in  NB_STREAMS×$clog2(NB_REG)  uloop register used by each stream
- uloop_ctrl_o  out  ctrl_uloop_t  enable/clear toward uloop engine
- uloop_flags_i  in  flags_uloop_t  valid, done, offs[], idx_update[] from engine
- desc_valid_o  out  1  descriptor available
- desc_ready_i  in  1  consumer accepts descriptor
- desc_o  out  uloop_issue_desc_t  addr[NB_STREAMS], idx_update[NB_LOOPS], last
- busy_o  out  1  high from start accept until done_o
- done_o  out  1  one-cycle pulse after last descriptor is popped

## Operation
- FSM states: IDLE, CLR, REQ, WAIT, DRAIN.
- IDLE: start_i → CLR.
- CLR: uloop_ctrl_o.clear=1 for exactly one cycle → REQ.
- REQ: if FIFO not full, uloop_ctrl_o.enable=1 for one cycle → WAIT. Otherwise stay, enable=0.
- WAIT: on uloop_flags_i.valid, push descriptor.
  - addr[s] = base_addr_i[s] + offs[offs_sel_i[s]], modulo 2^ADDR_WIDTH, carry dropped.
  - idx_update = flags idx_update[NB_LOOPS-1:0].
  - last = flags.done.
  - Then → DRAIN if last, else → REQ.
- DRAIN: when FIFO is empty (last popped), done_o=1 for one cycle → IDLE.
- At most one uloop request is outstanding. Enable is issued only when the FIFO is not full, so a push never hits a full FIFO (no overflow path).
- uloop_ctrl_o.clear = clear_i | (state==CLR). uloop_ctrl_o.enable is never high in the same cycle as clear.
- FIFO: desc_valid_o = ~empty. Pop on desc_valid_o & desc_ready_i. Push and pop in the same cycle keep the count.
- desc_o is stable while desc_valid_o=1 and desc_ready_i=0.
- busy_o = (state != IDLE).
- Reset or clear in any state: → IDLE, FIFO flushed, count=0, no done_o, outstanding request abandoned.

## Timing
- Reset values: desc_valid_o=0, desc_o='0, uloop_ctrl_o='0, busy_o=0, done_o=0.
- start_i at cycle t:
  - clear at t+1;
  - enable at t+2;
  - flags valid at t+3, from the shadowed engine's one-cycle reply;
  - push at t+3, so desc_valid_o=1 at t+4.
- A steady stream with desc_ready_i=1 gives one descriptor every 2 cycles (REQ, WAIT).
- WAIT holds indefinitely if flags.valid is late; no timeout.
- flags.valid outside WAIT is ignored.
- done_o comes 1 cycle after the pop of the last descriptor.
- start_i coincident with clear_i: the clear wins, and the block stays IDLE.

## Structure
- Add to hwpe_ctrl_package:
  - uloop_issue_desc_t, sized by ULOOP_MAX_NB_LOOPS and a new ULOOP_ISSUE_MAX_STREAMS constant;
  - the FSM state enum uloop_issue_state_t.
- Sub-module hwpe_ctrl_desc_fifo: parametric width and depth, sync reset/clear, push/pop/full/empty. Pointer wrap is modulo FIFO_DEPTH, so depth need not be a power of two.
- The adder array is inline in the top level.

## Test plan
- Single iteration: stub returns offs[0]=0x40 and done=1; base[0]=0x1000, sel[0]=0.
  - Expect desc addr[0]=0x1040 and last=1.
  - Expect done_o exactly 1 cycle after the pop, then busy_o=0.
- Backpressure, FIFO_DEPTH=2, desc_ready_i=0: after two pushes the FSM parks in REQ with enable=0. Releasing ready resumes requests, and order and values are preserved.
- Wrap arithmetic: base=0xFFFF_FFF0, offs=0x20 → addr=0x0000_0010.
- Per-stream select: sel={3,2,1,0} with offs={0x10,0x20,0x30,0x40} and all bases=0 → addr={0x40,0x30,0x20,0x10}.
- Mid-run clear_i while in WAIT with 1 descriptor buffered:
  - next cycle: IDLE, desc_valid_o=0, uloop_ctrl_o.clear=1;
  - no done_o;
  - a new start_i works normally.
- start_i pulses while busy are ignored, with no extra CLR cycle. Late flags (valid 5 cycles after enable) push exactly once.
